action_ctrl_hub: RTL
====================

# action_ctrl_hub

Control-plane hub for a SNAP action that hosts an accelerator core. It terminates the host AXI-lite control bus, serves the SNAP action registers locally, forwards all addresses at or above `CORE_BASE` to the core's AXI-lite slave with a response timeout, and runs a parametrised multi-source interrupt controller with the SNAP `interrupt`/`interrupt_ack` handshake. It sits between the SNAP shell and the core inside `action_wrapper`.

## Interface
**Reset:** one clock, `ap_clk`; reset `ap_rst` is synchronous and active-high.

**Parameters**
- `ADDR_W`, 32: AXI-lite address width.
- `DATA_W`, 32: AXI-lite data width.
- `NUM_IRQ`, 4: interrupt sources. Must be ≤ 2^(`INT_BITS`-1).
- `INT_BITS`, 3: SNAP interrupt field width.
- `CONTEXT_BITS`, 8: context width.
- `CORE_BASE`, 32'h0000_1000: first forwarded address.
- `TIMEOUT_CYC`, 256: core response timeout, in cycles.
- `ACTION_TYPE`, 32'h0000_0006: read-only value.
- `ACTION_VERSION`, 32'h0000_0006: read-only value.

**Ports**
- `ap_clk`, in, 1: clock.
- `ap_rst`, in, 1: synchronous reset, active-high.
- `s_axi_aw{addr,valid}` in / `awready` out, `ADDR_W`/1/1: host write address.
- `s_axi_w{data,strb,valid}` in / `wready` out, `DATA_W`/`DATA_W`/8/1/1: host write data.
- `s_axi_b{resp,valid}` out / `bready` in, 2/1/1: host write response.
- `s_axi_ar{addr,valid}` in / `arready` out: host read address.
- `s_axi_r{data,resp,valid}` out / `rready` in: host read data.
- `m_core_*`: the same five channels, mirrored direction, toward the core.
- `app_ready`, in, 1: core ready status.
- `irq_i`, in, `NUM_IRQ`: level interrupt requests from the core.
- `interrupt`, out, 1: interrupt request to SNAP.
- `interrupt_src`, out, `INT_BITS`-1: index of the source being signalled.
- `interrupt_ctx`, out, `CONTEXT_BITS`: context register value.
- `interrupt_ack`, in, 1: SNAP acknowledge.

## Operation
**Local registers** (addresses below `CORE_BASE`):
- 0x00 CONTROL:
  - bit0 `app_ready` (RO).
  - bit1 `core_dead` (RO).
  - bit2 writing 1 clears `core_dead`; reads as 0.
- 0x10 `ACTION_TYPE` (RO).
- 0x14 `ACTION_VERSION` (RO).
- 0x20 CONTEXT (RW, low `CONTEXT_BITS`).
- 0x24 INT_ENABLE (RW, `NUM_IRQ` bits).
- 0x28 INT_PENDING (W1C).

Other local addresses read 0 and ignore writes. All local responses are OKAY. Writes honour `wstrb`.

**Transaction FSM** (one transaction at a time). States: IDLE, L_WRESP, L_RRESP, C_WADDR, C_WRESP, C_RADDR, C_RRESP.
- IDLE:
  - AW and W are latched independently, in either order; `awready`/`wready` are high only while their latch is empty.
  - Arbitration: when a complete write and a read are both pending, they alternate (round-robin), starting with the read after reset.
- Core write (C_WADDR):
  - Drives `m_core_awvalid` and `m_core_wvalid`; each drops on its own ready.
  - Moves to C_WRESP once both have been accepted.
  - The core's `bresp` is forwarded unchanged.
- Core reads follow the same pattern through C_RADDR and C_RRESP.
- Timeout:
  - A counter starts when the core request is issued.
  - If `TIMEOUT_CYC` cycles pass without a core B/R response: answer the host with SLVERR (read data 0) and set `core_dead`.
- While `core_dead` is set:
  - Core-region accesses get SLVERR without touching the core.
  - `m_core_bready` and `m_core_rready` are held at 1 to drain late responses.

**Interrupts**
- A rising edge on `irq_i[k]` sets `pending[k]`.
- In interrupt-idle state, the lowest k with `pending[k] & enable[k]` is latched as `interrupt_src`, and `interrupt` is raised.
- `interrupt_ack` sampled while `interrupt` is high:
  - drops `interrupt` and clears the in-flight pending bit;
  - if a new edge on the same source arrives in the same cycle, the bit stays set.
- An ack while `interrupt` is low is ignored.
- W1C of the in-flight bit, or disabling it, does not withdraw the raised interrupt.

## Timing
- **Reset:** every output is 0, including all valids, readies, `interrupt`, and src/ctx. All registers are 0, the FSMs return to IDLE, and the timeout counter is cleared. A reset mid-transaction discards it with no response.
- **Local read:** AR handshake at cycle N gives `rvalid` at N+1.
- **Local write:** the second of AW/W is latched at N; `bvalid` is asserted at N+1; register update is visible to a read accepted at N+1.
- **Host response:** `rvalid`/`bvalid` stay high until ready.
- **Ready signals:** `arready` is high only in IDLE with no arbitration loss.
- **Core forward:** `m_core_*valid` is asserted the cycle after host acceptance.
- **Timeout:** SLVERR is presented exactly `TIMEOUT_CYC` cycles after issue.
- **Interrupt raise:** `irq_i` edge at N sets pending at N+1; `interrupt` rises at N+2 when enabled and idle.
- **Interrupt retire:** ack at M gives `interrupt` low at M+1. The next interrupt rises no earlier than M+2.
- **Context:** `interrupt_ctx` is sampled at raise and held stable while `interrupt` is high.

## Structure
- Package `action_ctrl_pkg`: register offsets, CONTROL bit indices, FSM state enum, AXI resp constants (OKAY=2'b00, SLVERR=2'b10).
- Sub-module `action_irq_ctrl`: edge detect, pending/enable, priority pick, ack handshake.
- The top module holds the AXI FSM and the register file.

## Test plan
- Read 0x10 and 0x14 → 0x0000_0006, OKAY, `rvalid` one cycle after AR.
- Present W three cycles before AW, writing 0x20 = 0xA5 → one B OKAY; a subsequent read of 0x20 returns 0xA5.
- Write 0x1004 with the core answering after 5 cycles → `m_core_awaddr`=0x1004, host B equals the core's bresp.
- Core-region read with a silent core → SLVERR at exactly 256 cycles; CONTROL bit1=1; the next core read gets an immediate SLVERR; writing 0x4 to CONTROL clears bit1.
- Enable=0xF; pulse `irq_i[2]` and `irq_i[1]` together → src=1 first; ack → src=2 raised 2 cycles later; `interrupt_ctx`=CONTEXT.
- Assert `ap_rst` during C_RRESP → all outputs 0 next cycle; a fresh read afterwards completes normally.

Source files
------------

// File: rtl/action_ctrl_pkg.sv
// Shared definitions for the SNAP action control hub: register map, CONTROL bits,
// AXI response codes and FSM state types.
package action_ctrl_pkg;

    localparam logic [11:0] REG_CONTROL        = 12'h000;
    localparam logic [11:0] REG_ACTION_TYPE    = 12'h010;
    localparam logic [11:0] REG_ACTION_VERSION = 12'h014;
    localparam logic [11:0] REG_CONTEXT        = 12'h020;
    localparam logic [11:0] REG_INT_ENABLE     = 12'h024;
    localparam logic [11:0] REG_INT_PENDING    = 12'h028;

    localparam int unsigned CTRL_APP_READY = 0;
    localparam int unsigned CTRL_CORE_DEAD = 1;
    localparam int unsigned CTRL_CLR_DEAD  = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        StIdle, StLWresp, StLRresp, StCWaddr, StCWresp, StCRaddr, StCRresp
    } hub_state_e;

    typedef enum logic {IrqIdle, IrqBusy} irq_state_e;

endpackage

// File: rtl/action_irq_ctrl.sv
// Multi-source interrupt controller: rising-edge capture into pending bits, lowest-index
// priority pick and the SNAP interrupt/ack handshake.
module action_irq_ctrl
    import action_ctrl_pkg::*;
#(
    parameter int unsigned NUM_IRQ      = 4,
    parameter int unsigned SRC_W        = 2,
    parameter int unsigned CONTEXT_BITS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IRQ-1:0]      irq_lvl,
    input  logic [NUM_IRQ-1:0]      enable,
    input  logic [NUM_IRQ-1:0]      w1c_mask,
    input  logic                    ack,
    input  logic [CONTEXT_BITS-1:0] context_val,
    output logic [NUM_IRQ-1:0]      pending,
    output logic                    interrupt,
    output logic [SRC_W-1:0]        src,
    output logic [CONTEXT_BITS-1:0] int_ctx
);

    irq_state_e           st;
    logic [NUM_IRQ-1:0]   irq_prev;
    logic [NUM_IRQ-1:0]   edges;
    logic [NUM_IRQ-1:0]   eligible;
    logic [NUM_IRQ-1:0]   ack_clr;
    logic                 found;
    logic [SRC_W-1:0]     pick;

    always_comb begin
        edges    = irq_lvl & ~irq_prev;
        eligible = pending & enable;
        found    = 1'b0;
        pick     = '0;
        // Descending scan so the lowest eligible index wins.
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (eligible[k]) begin
                found = 1'b1;
                pick  = SRC_W'(k);
            end
        end
        ack_clr = '0;
        if (st == IrqBusy && ack) begin
            ack_clr = NUM_IRQ'(1) << src;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= IrqIdle;
            irq_prev  <= '0;
            pending   <= '0;
            interrupt <= 1'b0;
            src       <= '0;
            int_ctx   <= '0;
        end else begin
            irq_prev <= irq_lvl;
            // A fresh edge in the ack cycle keeps the bit set.
            pending  <= (pending & ~w1c_mask & ~ack_clr) | edges;
            unique case (st)
                IrqIdle: begin
                    if (found) begin
                        st        <= IrqBusy;
                        interrupt <= 1'b1;
                        src       <= pick;
                        int_ctx   <= context_val;
                    end
                end
                IrqBusy: begin
                    if (ack) begin
                        st        <= IrqIdle;
                        interrupt <= 1'b0;
                    end
                end
                default: st <= IrqIdle;
            endcase
        end
    end

endmodule

// File: rtl/action_ctrl_hub.sv
// Control-plane hub: host AXI-lite termination, local SNAP registers, forwarding of the
// core region with a response timeout, and the interrupt controller.
module action_ctrl_hub
    import action_ctrl_pkg::*;
#(
    parameter int unsigned     ADDR_W         = 32,
    parameter int unsigned     DATA_W         = 32,
    parameter int unsigned     NUM_IRQ        = 4,
    parameter int unsigned     INT_BITS       = 3,
    parameter int unsigned     CONTEXT_BITS   = 8,
    parameter logic [ADDR_W-1:0] CORE_BASE    = 32'h0000_1000,
    parameter int unsigned     TIMEOUT_CYC    = 256,
    parameter logic [31:0]     ACTION_TYPE    = 32'h0000_0006,
    parameter logic [31:0]     ACTION_VERSION = 32'h0000_0006
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    input  logic [ADDR_W-1:0]       s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_W-1:0]       s_axi_wdata,
    input  logic [DATA_W/8-1:0]     s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_W-1:0]       s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_W-1:0]       s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [ADDR_W-1:0]       m_core_awaddr,
    output logic                    m_core_awvalid,
    input  logic                    m_core_awready,
    output logic [DATA_W-1:0]       m_core_wdata,
    output logic [DATA_W/8-1:0]     m_core_wstrb,
    output logic                    m_core_wvalid,
    input  logic                    m_core_wready,
    input  logic [1:0]              m_core_bresp,
    input  logic                    m_core_bvalid,
    output logic                    m_core_bready,
    output logic [ADDR_W-1:0]       m_core_araddr,
    output logic                    m_core_arvalid,
    input  logic                    m_core_arready,
    input  logic [DATA_W-1:0]       m_core_rdata,
    input  logic [1:0]              m_core_rresp,
    input  logic                    m_core_rvalid,
    output logic                    m_core_rready,
    input  logic                    app_ready,
    input  logic [NUM_IRQ-1:0]      irq_i,
    output logic                    interrupt,
    output logic [INT_BITS-2:0]     interrupt_src,
    output logic [CONTEXT_BITS-1:0] interrupt_ctx,
    input  logic                    interrupt_ack
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYC) + 1;

    hub_state_e              state;
    logic                    live, rr_read_turn, core_dead;
    logic                    aw_full, w_full;
    logic [ADDR_W-1:0]       aw_addr_q;
    logic [DATA_W-1:0]       w_data_q;
    logic [STRB_W-1:0]       w_strb_q;
    logic [CONTEXT_BITS-1:0] ctx_reg;
    logic [NUM_IRQ-1:0]      int_enable, int_pending, int_w1c;
    logic [CNT_W-1:0]        tmo_cnt;

    logic                    aw_hs, w_hs, wr_pend, wr_go, ar_go, idle, tmo;
    logic                    wr_core, ar_core;
    logic [ADDR_W-1:0]       wr_addr;
    logic [DATA_W-1:0]       wr_data, wr_mask, rd_local;
    logic [STRB_W-1:0]       wr_strb;

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_v,
                                                input logic [DATA_W-1:0] new_v,
                                                input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] r;
        r = old_v;
        for (int i = 0; i < STRB_W; i++) begin
            if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    // A write may complete from the latches, the live bus, or one of each.
    assign idle          = live && (state == StIdle);
    assign s_axi_awready = live && !aw_full;
    assign s_axi_wready  = live && !w_full;
    assign aw_hs         = s_axi_awvalid && s_axi_awready;
    assign w_hs          = s_axi_wvalid && s_axi_wready;
    assign wr_addr       = aw_full ? aw_addr_q : s_axi_awaddr;
    assign wr_data       = w_full ? w_data_q : s_axi_wdata;
    assign wr_strb       = w_full ? w_strb_q : s_axi_wstrb;
    assign wr_pend       = (aw_full || aw_hs) && (w_full || w_hs);
    assign s_axi_arready = idle && !(wr_pend && !rr_read_turn);
    assign ar_go         = s_axi_arvalid && s_axi_arready;
    assign wr_go         = idle && wr_pend && !ar_go;
    assign wr_core       = wr_addr >= CORE_BASE;
    assign ar_core       = s_axi_araddr >= CORE_BASE;
    assign wr_mask       = merge('0, wr_data, wr_strb);
    assign tmo           = tmo_cnt == CNT_W'(TIMEOUT_CYC - 1);
    assign m_core_bready = (state == StCWresp) || core_dead;
    assign m_core_rready = (state == StCRresp) || core_dead;
    assign int_w1c       = (wr_go && !wr_core && wr_addr == ADDR_W'(REG_INT_PENDING))
                           ? wr_mask[NUM_IRQ-1:0] : '0;

    always_comb begin
        rd_local = '0;
        case (s_axi_araddr)
            ADDR_W'(REG_CONTROL): begin
                rd_local[CTRL_APP_READY] = app_ready;
                rd_local[CTRL_CORE_DEAD] = core_dead;
            end
            ADDR_W'(REG_ACTION_TYPE):    rd_local = DATA_W'(ACTION_TYPE);
            ADDR_W'(REG_ACTION_VERSION): rd_local = DATA_W'(ACTION_VERSION);
            ADDR_W'(REG_CONTEXT):        rd_local = DATA_W'(ctx_reg);
            ADDR_W'(REG_INT_ENABLE):     rd_local = DATA_W'(int_enable);
            ADDR_W'(REG_INT_PENDING):    rd_local = DATA_W'(int_pending);
            default:                     rd_local = '0;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state          <= StIdle;
            live           <= 1'b0;
            rr_read_turn   <= 1'b1;
            core_dead      <= 1'b0;
            aw_full        <= 1'b0;
            w_full         <= 1'b0;
            aw_addr_q      <= '0;
            w_data_q       <= '0;
            w_strb_q       <= '0;
            ctx_reg        <= '0;
            int_enable     <= '0;
            tmo_cnt        <= '0;
            s_axi_bresp    <= RESP_OKAY;
            s_axi_bvalid   <= 1'b0;
            s_axi_rdata    <= '0;
            s_axi_rresp    <= RESP_OKAY;
            s_axi_rvalid   <= 1'b0;
            m_core_awaddr  <= '0;
            m_core_awvalid <= 1'b0;
            m_core_wdata   <= '0;
            m_core_wstrb   <= '0;
            m_core_wvalid  <= 1'b0;
            m_core_araddr  <= '0;
            m_core_arvalid <= 1'b0;
        end else begin
            live    <= 1'b1;
            tmo_cnt <= tmo_cnt + CNT_W'(1);
            if (wr_go) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
            end else begin
                if (aw_hs) begin
                    aw_full   <= 1'b1;
                    aw_addr_q <= s_axi_awaddr;
                end
                if (w_hs) begin
                    w_full   <= 1'b1;
                    w_data_q <= s_axi_wdata;
                    w_strb_q <= s_axi_wstrb;
                end
            end
            if (ar_go)      rr_read_turn <= 1'b0;
            else if (wr_go) rr_read_turn <= 1'b1;

            unique case (state)
                StIdle: begin
                    if (ar_go) begin
                        if (ar_core && !core_dead) begin
                            m_core_arvalid <= 1'b1;
                            m_core_araddr  <= s_axi_araddr;
                            tmo_cnt        <= '0;
                            state          <= StCRaddr;
                        end else begin
                            s_axi_rvalid <= 1'b1;
                            s_axi_rdata  <= ar_core ? '0 : rd_local;
                            s_axi_rresp  <= ar_core ? RESP_SLVERR : RESP_OKAY;
                            state        <= StLRresp;
                        end
                    end else if (wr_go) begin
                        if (wr_core && !core_dead) begin
                            m_core_awvalid <= 1'b1;
                            m_core_wvalid  <= 1'b1;
                            m_core_awaddr  <= wr_addr;
                            m_core_wdata   <= wr_data;
                            m_core_wstrb   <= wr_strb;
                            tmo_cnt        <= '0;
                            state          <= StCWaddr;
                        end else begin
                            s_axi_bvalid <= 1'b1;
                            s_axi_bresp  <= wr_core ? RESP_SLVERR : RESP_OKAY;
                            state        <= StLWresp;
                            if (!wr_core) begin
                                case (wr_addr)
                                    ADDR_W'(REG_CONTROL):
                                        if (wr_mask[CTRL_CLR_DEAD]) core_dead <= 1'b0;
                                    ADDR_W'(REG_CONTEXT):
                                        ctx_reg <= CONTEXT_BITS'(merge(DATA_W'(ctx_reg),
                                                                       wr_data, wr_strb));
                                    ADDR_W'(REG_INT_ENABLE):
                                        int_enable <= NUM_IRQ'(merge(DATA_W'(int_enable),
                                                                     wr_data, wr_strb));
                                    default: ;
                                endcase
                            end
                        end
                    end
                end
                StLWresp: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid <= 1'b0;
                        state        <= StIdle;
                    end
                end
                StLRresp: begin
                    if (s_axi_rready) begin
                        s_axi_rvalid <= 1'b0;
                        state        <= StIdle;
                    end
                end
                StCWaddr: begin
                    if (tmo) begin
                        m_core_awvalid <= 1'b0;
                        m_core_wvalid  <= 1'b0;
                        core_dead      <= 1'b1;
                        s_axi_bvalid   <= 1'b1;
                        s_axi_bresp    <= RESP_SLVERR;
                        state          <= StLWresp;
                    end else begin
                        if (m_core_awready) m_core_awvalid <= 1'b0;
                        if (m_core_wready)  m_core_wvalid  <= 1'b0;
                        if ((!m_core_awvalid || m_core_awready) &&
                            (!m_core_wvalid || m_core_wready)) begin
                            state <= StCWresp;
                        end
                    end
                end
                StCWresp: begin
                    if (m_core_bvalid || tmo) begin
                        s_axi_bvalid <= 1'b1;
                        s_axi_bresp  <= m_core_bvalid ? m_core_bresp : RESP_SLVERR;
                        if (!m_core_bvalid) core_dead <= 1'b1;
                        state        <= StLWresp;
                    end
                end
                StCRaddr: begin
                    if (tmo) begin
                        m_core_arvalid <= 1'b0;
                        core_dead      <= 1'b1;
                        s_axi_rvalid   <= 1'b1;
                        s_axi_rdata    <= '0;
                        s_axi_rresp    <= RESP_SLVERR;
                        state          <= StLRresp;
                    end else if (m_core_arready) begin
                        m_core_arvalid <= 1'b0;
                        state          <= StCRresp;
                    end
                end
                StCRresp: begin
                    if (m_core_rvalid || tmo) begin
                        s_axi_rvalid <= 1'b1;
                        s_axi_rdata  <= m_core_rvalid ? m_core_rdata : '0;
                        s_axi_rresp  <= m_core_rvalid ? m_core_rresp : RESP_SLVERR;
                        if (!m_core_rvalid) core_dead <= 1'b1;
                        state        <= StLRresp;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    action_irq_ctrl #(
        .NUM_IRQ      (NUM_IRQ),
        .SRC_W        (INT_BITS - 1),
        .CONTEXT_BITS (CONTEXT_BITS)
    ) u_irq (
        .clk         (ap_clk),
        .rst         (ap_rst),
        .irq_lvl     (irq_i),
        .enable      (int_enable),
        .w1c_mask    (int_w1c),
        .ack         (interrupt_ack),
        .context_val (ctx_reg),
        .pending     (int_pending),
        .interrupt   (interrupt),
        .src         (interrupt_src),
        .int_ctx     (interrupt_ctx)
    );

endmodule
